// File: rtl/cpu_bus_responder.sv
// CPU management bus slave holding the per-VPI cell configuration table.
// Intel/Motorola bus cycles with programmable wait states plus a registered datapath lookup port.
module cpu_bus_responder #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              BusMode,
  input  logic              Sel,
  input  logic              Rd_DS,
  input  logic              Wr_RW,
  input  logic [11:0]       Addr,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              Rdy_Dtack,
  input  logic [7:0]        lut_idx,
  output logic [DATA_W-1:0] lut_data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [8:0] DEPTH_L = 9'(DEPTH);
  localparam logic [3:0] WS_L    = 4'(WAIT_STATES);

  state_t              state_q, state_d;
  logic [11:0]         addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                rdy_q, rdy_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [DATA_W-1:0]   lut_q, lut_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic                start;
  logic                active;
  logic                in_range;

  // Intel requires exactly one strobe low; Wr_RW low means write in both modes.
  assign start    = BusMode ? (!Sel && (Rd_DS ^ Wr_RW)) : (!Sel && !Rd_DS);
  assign active   = BusMode ? (!Sel && (wr_q ? !Wr_RW : !Rd_DS)) : (!Sel && !Rd_DS);
  assign in_range = (addr_q[11:8] == 4'd0) && ({1'b0, addr_q[7:0]} < DEPTH_L);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    rdy_d   = rdy_q;
    dout_d  = dout_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        rdy_d  = 1'b1;
        dout_d = '0;
        if (start) begin
          state_d = S_WAIT;
          addr_d  = Addr;
          wr_d    = !Wr_RW;
          din_d   = DataIn;
          cnt_d   = WS_L;
        end
      end
      S_WAIT: begin
        if (!active) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          rdy_d   = 1'b0;
          if (wr_q) begin
            mem_we = in_range;
            dout_d = '0;
          end else begin
            dout_d = in_range ? mem_q[addr_q[7:0]] : '0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        if (!active) begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
          dout_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lookup sees the table before this cycle's bus write lands.
  always_comb begin
    lut_d = '0;
    if ({1'b0, lut_idx} < DEPTH_L) lut_d = mem_q[lut_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      din_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      dout_q  <= '0;
      lut_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      dout_q  <= dout_d;
      lut_q   <= lut_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_q[7:0]] <= din_q;
    end
  end

  assign DataOut   = dout_q;
  assign Rdy_Dtack = rdy_q;
  assign lut_data  = lut_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: bus handshakes, range handling, abort, lookup and reset.
module tb_cpu_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        BusMode;
  logic        Sel;
  logic        Rd_DS;
  logic        Wr_RW;
  logic [11:0] Addr;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        Rdy_Dtack;
  logic [7:0]  lut_idx;
  logic [15:0] lut_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_bus_responder #(.DATA_W(16), .DEPTH(256), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .BusMode(BusMode), .Sel(Sel), .Rd_DS(Rd_DS),
    .Wr_RW(Wr_RW), .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut),
    .Rdy_Dtack(Rdy_Dtack), .lut_idx(lut_idx), .lut_data(lut_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    Sel   = 1'b1;
    Rd_DS = 1'b1;
    Wr_RW = 1'b1;
  endtask

  task automatic drive_req(input bit intel, input bit wr, input logic [11:0] a, input logic [15:0] d);
    BusMode = intel;
    Sel     = 1'b0;
    Addr    = a;
    DataIn  = d;
    if (intel) begin
      Rd_DS = wr ? 1'b1 : 1'b0;
      Wr_RW = wr ? 1'b0 : 1'b1;
    end else begin
      Rd_DS = 1'b0;
      Wr_RW = wr ? 1'b0 : 1'b1;
    end
  endtask

  // Full cycle: lat = edges after the sampling edge until Rdy_Dtack low (-1 on timeout).
  task automatic do_access(input bit intel, input bit wr, input logic [11:0] a, input logic [15:0] d,
                           output int lat, output logic [15:0] dat_ack,
                           output logic rdy_after, output logic [15:0] dat_after);
    lat     = -1;
    dat_ack = 'x;
    drive_req(intel, wr, a, d);
    tick();
    DataIn = ~d;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (Rdy_Dtack === 1'b0) begin
        lat = i;
        break;
      end
    end
    dat_ack = DataOut;
    bus_idle();
    tick();
    rdy_after = Rdy_Dtack;
    dat_after = DataOut;
    tick();
  endtask

  task automatic lut_read(input logic [7:0] idx, output logic [15:0] val);
    lut_idx = idx;
    tick();
    val = lut_data;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst = 1'b1;
    bus_idle();
    BusMode = 1'b1;
    Addr    = '0;
    DataIn  = '0;
    lut_idx = 8'h10;
    #2;
    checks++;
    if (Rdy_Dtack !== 1'b1 || DataOut !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b dout=%h, required rdy=1 dout=0000", Rdy_Dtack, DataOut);
    end
    tick();
    tick();
    rst = 1'b0;
    lut_read(8'h10, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++;
      $display("FAIL reset_lut: got %h, required 0000", v);
    end
  endtask

  task automatic test_intel();
    int lat;
    logic [15:0] da, dd, v;
    logic ra;
    do_access(1'b1, 1'b1, 12'h010, 16'h5A3C, lat, da, ra, dd);
    checks++;
    if (lat != 3 || da !== 16'h0000 || ra !== 1'b1 || dd !== 16'h0000) begin
      errors++;
      $display("FAIL intel_write: lat=%0d ackdata=%h rdy_after=%b dout_after=%h, required 3 0000 1 0000", lat, da, ra, dd);
    end
    do_access(1'b1, 1'b0, 12'h010, 16'h0000, lat, da, ra, dd);
    checks++;
    if (lat != 3 || da !== 16'h5A3C) begin
      errors++;
      $display("FAIL intel_read: lat=%0d data=%h, required 3 5a3c", lat, da);
    end
    checks++;
    if (ra !== 1'b1 || dd !== 16'h0000) begin
      errors++;
      $display("FAIL intel_release: rdy=%b dout=%h, required 1 0000", ra, dd);
    end
    lut_read(8'h10, v);
    checks++;
    if (v !== 16'h5A3C) begin
      errors++;
      $display("FAIL intel_lut: got %h, required 5a3c", v);
    end
  endtask

  task automatic test_motorola();
    int lat;
    logic [15:0] da, dd;
    logic ra;
    do_access(1'b0, 1'b1, 12'h0FF, 16'h1234, lat, da, ra, dd);
    checks++;
    if (lat != 3 || ra !== 1'b1) begin
      errors++;
      $display("FAIL moto_write: lat=%0d rdy_after=%b, required 3 1", lat, ra);
    end
    do_access(1'b0, 1'b0, 12'h0FF, 16'h0000, lat, da, ra, dd);
    checks++;
    if (lat != 3 || da !== 16'h1234 || ra !== 1'b1 || dd !== 16'h0000) begin
      errors++;
      $display("FAIL moto_read: lat=%0d data=%h rdy_after=%b dout_after=%h, required 3 1234 1 0000", lat, da, ra, dd);
    end
  endtask

  task automatic test_out_of_range();
    int lat;
    logic [15:0] da, dd, v;
    logic ra;
    do_access(1'b1, 1'b1, 12'h100, 16'hFFFF, lat, da, ra, dd);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL oor_write_ack: lat=%0d, required 3", lat);
    end
    do_access(1'b1, 1'b0, 12'h100, 16'h0000, lat, da, ra, dd);
    checks++;
    if (lat != 3 || da !== 16'h0000) begin
      errors++;
      $display("FAIL oor_read_100: lat=%0d data=%h, required 3 0000", lat, da);
    end
    do_access(1'b1, 1'b0, 12'h000, 16'h0000, lat, da, ra, dd);
    checks++;
    if (lat != 3 || da !== 16'h0000) begin
      errors++;
      $display("FAIL oor_read_000: lat=%0d data=%h, required 3 0000", lat, da);
    end
    lut_read(8'h00, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++;
      $display("FAIL oor_lut_000: got %h, required 0000", v);
    end
  endtask

  task automatic test_abort_illegal();
    int lat;
    int lows;
    logic [15:0] da, dd, v;
    logic ra;
    drive_req(1'b1, 1'b1, 12'h020, 16'hBEEF);
    tick();
    tick();
    Sel  = 1'b1;
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (Rdy_Dtack !== 1'b1) lows++;
    end
    bus_idle();
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL abort_noack: low cycles=%0d, required 0", lows);
    end
    lut_read(8'h20, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++;
      $display("FAIL abort_entry: got %h, required 0000", v);
    end
    BusMode = 1'b1;
    Sel     = 1'b0;
    Rd_DS   = 1'b0;
    Wr_RW   = 1'b0;
    Addr    = 12'h010;
    lows    = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (Rdy_Dtack !== 1'b1) lows++;
    end
    bus_idle();
    tick();
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL illegal_noack: low cycles=%0d, required 0", lows);
    end
    do_access(1'b1, 1'b0, 12'h010, 16'h0000, lat, da, ra, dd);
    checks++;
    if (lat != 3 || da !== 16'h5A3C) begin
      errors++;
      $display("FAIL illegal_then_read: lat=%0d data=%h, required 3 5a3c", lat, da);
    end
  endtask

  task automatic test_lut_collision();
    lut_idx = 8'h20;
    drive_req(1'b1, 1'b1, 12'h020, 16'h0A0A);
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (Rdy_Dtack !== 1'b0 || lut_data !== 16'h0000) begin
      errors++;
      $display("FAIL lut_old: rdy=%b lut=%h, required 0 0000", Rdy_Dtack, lut_data);
    end
    tick();
    checks++;
    if (lut_data !== 16'h0A0A) begin
      errors++;
      $display("FAIL lut_new: got %h, required 0a0a", lut_data);
    end
    bus_idle();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [15:0] da, dd, v;
    logic ra;
    drive_req(1'b1, 1'b0, 12'h010, 16'h0000);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (Rdy_Dtack !== 1'b0 || DataOut !== 16'h5A3C) begin
      errors++;
      $display("FAIL pre_reset_ack: rdy=%b dout=%h, required 0 5a3c", Rdy_Dtack, DataOut);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (Rdy_Dtack !== 1'b1 || DataOut !== 16'h0000) begin
      errors++;
      $display("FAIL reset_async: rdy=%b dout=%h, required 1 0000", Rdy_Dtack, DataOut);
    end
    bus_idle();
    tick();
    rst = 1'b0;
    tick();
    drive_req(1'b1, 1'b1, 12'h030, 16'h7777);
    tick();
    tick();
    rst = 1'b1;
    bus_idle();
    tick();
    rst = 1'b0;
    tick();
    lut_read(8'h30, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++;
      $display("FAIL reset_inflight_write: got %h, required 0000", v);
    end
    lut_read(8'h10, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++;
      $display("FAIL reset_table_lut: got %h, required 0000", v);
    end
    do_access(1'b0, 1'b0, 12'h0FF, 16'h0000, lat, da, ra, dd);
    checks++;
    if (lat != 3 || da !== 16'h0000) begin
      errors++;
      $display("FAIL reset_table_bus: lat=%0d data=%h, required 3 0000", lat, da);
    end
  endtask

  initial begin
    test_reset();
    test_intel();
    test_motorola();
    test_out_of_range();
    test_abort_illegal();
    test_lut_collision();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
